// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing/stall controller:
// op-mode and state encodings plus the watchdog abort result.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        OP_IDLE        = 3'd0,
        OP_LOGIC       = 3'd1,
        OP_SHIFT       = 3'd2,
        OP_COMPARE     = 3'd3,
        OP_INT_ADD_SUB = 3'd4,
        OP_INT_MUL     = 3'd5,
        OP_INT_DIV     = 3'd6,
        OP_ILLEGAL     = 3'd7
    } op_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [DATA_W-1:0] TIMEOUT_RESULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/alu_wdog_cnt.sv
// Watchdog for multi-cycle ALU ops: counts enabled cycles since the last clear and
// flags the cycle in which the TIMEOUT_CYCLES-th enabled cycle occurs (0 = disabled).
module alu_wdog_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic        ARMED = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last   = (r_cnt == CNT_W'(LAST));
    assign o_expired_c = ARMED && i_enable && w_at_last;

    // Saturates at the last count; the FSM leaves WAIT on expiry anyway
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !w_at_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU sequencing/stall controller: registers single-cycle results, launches and waits on
// int_mul/int_div with a watchdog, and holds results until downstream takes them.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [MODE_W-1:0] i_op_mode,
    input  logic              i_rem_sel,
    input  logic [DATA_W-1:0] i_comb_result,
    output logic              o_stall,
    output logic              o_mul_start,
    output logic              o_div_start,
    input  logic              i_mul_valid,
    input  logic [DATA_W-1:0] i_mul_result,
    input  logic              i_div_valid,
    input  logic [DATA_W-1:0] i_div_quot,
    input  logic [DATA_W-1:0] i_div_rem,
    input  logic              i_stall,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_result,
    output logic              o_illegal,
    output logic              o_timeout
);

    state_e            r_state,     w_state_nxt;
    logic              r_valid,     w_valid_nxt;
    logic [DATA_W-1:0] r_result,    w_result_nxt;
    logic              r_mul_start, w_mul_start_nxt;
    logic              r_div_start, w_div_start_nxt;
    logic              r_illegal,   w_illegal_nxt;
    logic              r_timeout,   w_timeout_nxt;
    logic              r_is_div,    w_is_div_nxt;
    logic              r_rem_sel,   w_rem_sel_nxt;

    op_mode_e          w_mode;
    logic              w_sel_valid;
    logic [DATA_W-1:0] w_sel_result;
    logic              w_wd_clear;
    logic              w_wd_en;
    logic              w_wd_expired;

    assign w_mode       = op_mode_e'(i_op_mode);
    // Only the unit launched by this op may complete it
    assign w_sel_valid  = r_is_div ? i_div_valid : i_mul_valid;
    assign w_sel_result = r_is_div ? (r_rem_sel ? i_div_rem : i_div_quot) : i_mul_result;

    alu_wdog_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_wd_clear),
        .i_enable    (w_wd_en),
        .o_expired_c (w_wd_expired)
    );

    // Next-state, next-output and issue-stage stall
    always_comb begin
        w_state_nxt     = r_state;
        w_valid_nxt     = r_valid;
        w_result_nxt    = r_result;
        w_mul_start_nxt = 1'b0;
        w_div_start_nxt = 1'b0;
        w_illegal_nxt   = 1'b0;
        w_timeout_nxt   = r_timeout;
        w_is_div_nxt    = r_is_div;
        w_rem_sel_nxt   = r_rem_sel;
        w_wd_clear      = 1'b0;
        w_wd_en         = 1'b0;
        o_stall         = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (r_state == ST_DONE && i_stall) begin
                    o_stall = 1'b1;
                end else if (i_valid) begin
                    case (w_mode)
                        OP_LOGIC, OP_SHIFT, OP_COMPARE, OP_INT_ADD_SUB: begin
                            w_state_nxt  = ST_DONE;
                            w_valid_nxt  = 1'b1;
                            w_result_nxt = i_comb_result;
                        end
                        OP_INT_MUL, OP_INT_DIV: begin
                            w_state_nxt     = ST_ISSUE;
                            w_valid_nxt     = 1'b0;
                            w_is_div_nxt    = (w_mode == OP_INT_DIV);
                            w_rem_sel_nxt   = i_rem_sel;
                            w_mul_start_nxt = (w_mode == OP_INT_MUL);
                            w_div_start_nxt = (w_mode == OP_INT_DIV);
                            o_stall         = 1'b1;
                        end
                        OP_ILLEGAL: begin
                            w_state_nxt   = ST_IDLE;
                            w_valid_nxt   = 1'b0;
                            w_illegal_nxt = 1'b1;
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                            w_valid_nxt = 1'b0;
                        end
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            ST_ISSUE: begin
                o_stall     = 1'b1;
                w_wd_clear  = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                o_stall = 1'b1;
                if (w_sel_valid) begin
                    w_state_nxt  = ST_DONE;
                    w_valid_nxt  = 1'b1;
                    w_result_nxt = w_sel_result;
                end else begin
                    w_wd_en = 1'b1;
                    if (w_wd_expired) begin
                        w_state_nxt   = ST_DONE;
                        w_valid_nxt   = 1'b1;
                        w_result_nxt  = TIMEOUT_RESULT;
                        w_timeout_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_mul_start <= 1'b0;
            r_div_start <= 1'b0;
            r_illegal   <= 1'b0;
            r_timeout   <= 1'b0;
            r_is_div    <= 1'b0;
            r_rem_sel   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_valid     <= w_valid_nxt;
            r_result    <= w_result_nxt;
            r_mul_start <= w_mul_start_nxt;
            r_div_start <= w_div_start_nxt;
            r_illegal   <= w_illegal_nxt;
            r_timeout   <= w_timeout_nxt;
            r_is_div    <= w_is_div_nxt;
            r_rem_sel   <= w_rem_sel_nxt;
        end
    end

    assign o_valid     = r_valid;
    assign o_result    = r_result;
    assign o_mul_start = r_mul_start;
    assign o_div_start = r_div_start;
    assign o_illegal   = r_illegal;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed scenarios plus randomized op streams
// checked against a transaction-level model of the op rules.
module tb_alu_seq_ctrl;

    localparam int unsigned TO = 8;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [2:0]  i_op_mode;
    logic        i_rem_sel;
    logic [31:0] i_comb_result;
    logic        o_stall;
    logic        o_mul_start;
    logic        o_div_start;
    logic        i_mul_valid;
    logic [31:0] i_mul_result;
    logic        i_div_valid;
    logic [31:0] i_div_quot;
    logic [31:0] i_div_rem;
    logic        i_stall;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_illegal;
    logic        o_timeout;

    alu_seq_ctrl #(.TIMEOUT_CYCLES(TO)) u_dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .i_op_mode     (i_op_mode),
        .i_rem_sel     (i_rem_sel),
        .i_comb_result (i_comb_result),
        .o_stall       (o_stall),
        .o_mul_start   (o_mul_start),
        .o_div_start   (o_div_start),
        .i_mul_valid   (i_mul_valid),
        .i_mul_result  (i_mul_result),
        .i_div_valid   (i_div_valid),
        .i_div_quot    (i_div_quot),
        .i_div_rem     (i_div_rem),
        .i_stall       (i_stall),
        .o_valid       (o_valid),
        .o_result      (o_result),
        .o_illegal     (o_illegal),
        .o_timeout     (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_mul_pulse = 0;
    int n_div_pulse = 0;
    bit m_timeout = 1'b0;

    // Start pulses are tallied mid-cycle so each op can check how many it produced
    always @(negedge i_clk) begin
        if (o_mul_start === 1'b1) n_mul_pulse++;
        if (o_div_start === 1'b1) n_div_pulse++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] mode, input logic [31:0] comb,
                                               input logic [31:0] mulv, input logic [31:0] q,
                                               input logic [31:0] r, input logic rem);
        if (mode >= 3'd1 && mode <= 3'd4) return comb;
        if (mode == 3'd5) return mulv;
        if (mode == 3'd6) return rem ? r : q;
        return 32'h0;
    endfunction

    // One op: present, wait out any unit latency (with an optional stray from the other
    // unit), check the result, then hold it under downstream stall for dstall cycles.
    task automatic run_op(input logic [2:0] mode, input logic [31:0] comb, input logic rem,
                          input logic [31:0] mulv, input logic [31:0] q, input logic [31:0] r,
                          input int lat, input int stray_at, input int dstall);
        logic [31:0] exp;
        bit multi;
        bit has_result;
        int p_mul0;
        int p_div0;
        multi      = (mode == 3'd5) || (mode == 3'd6);
        has_result = (mode >= 3'd1) && (mode <= 3'd6);
        exp        = ref_result(mode, comb, mulv, q, r, rem);
        p_mul0     = n_mul_pulse;
        p_div0     = n_div_pulse;

        i_valid = 1'b1; i_op_mode = mode; i_comb_result = comb; i_rem_sel = rem; i_stall = 1'b0;
        #1 check("stall_accept", 32'(o_stall), 32'(multi));
        tick();
        i_valid = 1'b0; i_op_mode = 3'($urandom); i_comb_result = $urandom; i_rem_sel = 1'($urandom);
        if (multi) begin
            #1;
            check("stall_issue", 32'(o_stall), 32'd1);
            check("valid_issue", 32'(o_valid), 32'd0);
            for (int w = 1; w <= lat; w++) begin
                tick();
                i_mul_valid  = (mode == 3'd5) ? (w == lat) : (w == stray_at);
                i_div_valid  = (mode == 3'd6) ? (w == lat) : (w == stray_at);
                i_mul_result = (mode == 3'd5) ? mulv : $urandom;
                i_div_quot   = (mode == 3'd6) ? q : $urandom;
                i_div_rem    = (mode == 3'd6) ? r : $urandom;
                #1;
                check("stall_wait", 32'(o_stall), 32'd1);
                check("valid_wait", 32'(o_valid), 32'd0);
            end
            tick();
            i_mul_valid = 1'b0; i_div_valid = 1'b0;
        end
        check("valid_out", 32'(o_valid), 32'(has_result));
        check("illegal", 32'(o_illegal), 32'(mode == 3'd7));
        check("timeout_flag", 32'(o_timeout), 32'(m_timeout));
        check("mul_pulses", 32'(n_mul_pulse - p_mul0), 32'(mode == 3'd5));
        check("div_pulses", 32'(n_div_pulse - p_div0), 32'(mode == 3'd6));
        if (has_result) begin
            check("result", o_result, exp);
            for (int s = 0; s < dstall; s++) begin
                i_stall = 1'b1;
                #1 check("stall_down", 32'(o_stall), 32'd1);
                tick();
                check("valid_held", 32'(o_valid), 32'd1);
                check("result_held", o_result, exp);
            end
        end else if (mode == 3'd7) begin
            tick();
            check("illegal_pulse_end", 32'(o_illegal), 32'd0);
            check("illegal_no_valid", 32'(o_valid), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0; i_stall = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            check("idle_valid", 32'(o_valid), 32'd0);
            check("idle_stall", 32'(o_stall), 32'd0);
        end
    endtask

    task automatic timeout_case();
        i_valid = 1'b1; i_op_mode = 3'd6; i_rem_sel = 1'b0; i_stall = 1'b0;
        tick();
        i_valid = 1'b0;
        for (int w = 1; w <= int'(TO); w++) begin
            tick();
            check("to_waiting", 32'(o_valid), 32'd0);
        end
        tick();
        m_timeout = 1'b1;
        check("to_valid", 32'(o_valid), 32'd1);
        check("to_result", o_result, 32'hFFFF_FFFF);
        check("to_flag", 32'(o_timeout), 32'd1);
        i_div_valid = 1'b1; i_div_quot = 32'h1234; i_div_rem = 32'h5678; i_stall = 1'b1;
        tick();
        check("to_late_held", o_result, 32'hFFFF_FFFF);
        i_stall = 1'b0;
        tick();
        check("to_late_idle", 32'(o_valid), 32'd0);
        i_div_valid = 1'b0;
        tick();
        check("to_late_idle2", 32'(o_valid), 32'd0);
        check("to_sticky", 32'(o_timeout), 32'd1);
    endtask

    task automatic reset_mid_wait();
        i_valid = 1'b1; i_op_mode = 3'd5; i_stall = 1'b0;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        m_timeout = 1'b0;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_illegal", 32'(o_illegal), 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        check("rst_starts", 32'({o_mul_start, o_div_start}), 32'd0);
        check("rst_stall", 32'(o_stall), 32'd0);
        i_mul_valid = 1'b1; i_mul_result = 32'h77;
        tick();
        check("rst_stale_valid", 32'(o_valid), 32'd0);
        i_mul_valid = 1'b0;
        tick();
        check("rst_stale_valid2", 32'(o_valid), 32'd0);
    endtask

    initial begin
        logic [2:0] mode;
        int lat;
        i_rst = 1'b1; i_valid = 1'b0; i_op_mode = 3'd0; i_rem_sel = 1'b0; i_comb_result = '0;
        i_mul_valid = 1'b0; i_mul_result = '0; i_div_valid = 1'b0; i_div_quot = '0;
        i_div_rem = '0; i_stall = 1'b0;
        tick();
        tick();
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_result", o_result, 32'd0);
        check("reset_flags", 32'({o_illegal, o_timeout, o_mul_start, o_div_start}), 32'd0);
        check("reset_stall", 32'(o_stall), 32'd0);
        i_rst = 1'b0;
        tick();

        run_op(3'd4, 32'h5, 1'b0, 0, 0, 0, 0, 0, 0);
        run_op(3'd1, 32'hA5A5_0001, 1'b0, 0, 0, 0, 0, 0, 0);
        run_op(3'd2, 32'h0000_0F00, 1'b0, 0, 0, 0, 0, 0, 0);
        run_op(3'd3, 32'h0000_0001, 1'b0, 0, 0, 0, 0, 0, 0);
        idle(2);
        run_op(3'd5, 32'h0, 1'b0, 32'h2A, 0, 0, 4, 0, 0);
        run_op(3'd6, 32'h0, 1'b1, 0, 32'd3, 32'd1, 3, 2, 0);
        run_op(3'd4, 32'hDEAD_BEEF, 1'b0, 0, 0, 0, 0, 0, 5);
        run_op(3'd1, 32'h1357_9BDF, 1'b0, 0, 0, 0, 0, 0, 0);
        run_op(3'd7, 32'h0, 1'b0, 0, 0, 0, 0, 0, 0);
        run_op(3'd0, 32'h0, 1'b0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            mode = 3'($urandom);
            lat  = $urandom_range(1, TO - 1);
            run_op(mode, $urandom, 1'($urandom), $urandom, $urandom, $urandom,
                   lat, $urandom_range(0, lat), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        end

        idle(1);
        timeout_case();
        run_op(3'd6, 32'h0, 1'b0, 0, 32'h99, 32'h11, 2, 1, 1);
        reset_mid_wait();
        run_op(3'd4, 32'h0BAD_F00D, 1'b0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
